wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage plus architectural register file of the 5-stage RISC core. Sits directly downstream of the MEM/WB pipeline register. Selects the writeback value from the `_W` bundle, commits it on the clock edge, and serves the two decode-stage read ports with same-cycle write-through bypass. Also exports the selected writeback value for the hazard/forwarding unit.

## Interface
Parameters:
- `DW`, default 32: data width.
- `AW`, default 5: register address width; the file holds 2^AW entries.

Ports:
- `CLK` input 1: clock; all state updates on posedge.
- `RSTN` input 1: asynchronous active-low reset.
- `SelWB_W` input 2: writeback source select.
- `WEN_W` input 1: register write enable, active-low (0 = write).
- `ALUOUT_W` input DW: ALU result.
- `LoadData_W` input DW: load data.
- `PCADD4_W` input DW: link value (PC+4).
- `WA_W` input AW: write address.
- `RA1`, `RA2` input AW: decode-stage read addresses.
- `RD1`, `RD2` output DW: read data, combinational.
- `WBData_W` output DW: selected writeback value, combinational, for forwarding.

## Operation
- Writeback mux on `SelWB_W`:
  - 2'b00 selects `ALUOUT_W`.
  - 2'b01 selects `LoadData_W`.
  - 2'b10 selects `PCADD4_W`.
  - 2'b11 is reserved and selects `ALUOUT_W`.
- Register array: 2^AW entries × DW bits. No hardwired-zero register; every entry, including R0, is writable.
- Write: on posedge `CLK` with `RSTN`=1 and `WEN_W`=0, `R[WA_W] <= WBData_W`. With `WEN_W`=1 no entry changes.
- Read and bypass: `RDn = (WEN_W==0 && WA_W==RAn) ? WBData_W : R[RAn]`. Each port is evaluated independently, so both ports may hit the bypass at the same time.
- Identical read addresses (`RA1`==`RA2`) return identical data.
- Reset:
  - `RSTN`=0 clears every entry to 0 asynchronously.
  - While `RSTN`=0, `RD1` and `RD2` are forced to 0 and the bypass is suppressed.
  - `WBData_W` stays purely combinational and is not gated by reset.
- After the upstream stage releases reset it presents `WEN_W`=1, so the first post-reset cycle writes nothing.

## Timing
- Write latency: one edge. A value presented in cycle N is stored at the end of cycle N and is readable from the array in cycle N+1.
- Read latency: zero (combinational). The bypass delivers the cycle-N write value in cycle N, which covers a WB-to-ID distance of 0 without a stall.
- Simultaneous write and read of the same address: the read returns the new value (write-through).
- Reset asserted mid-operation:
  - The array clears immediately, not at the next edge.
  - A write coinciding with the reset-asserting edge is lost.
  - On the first posedge after `RSTN` rises, a write with `WEN_W`=0 is honoured.
- Reset values:
  - `RD1`, `RD2` are 0.
  - All entries are 0.
  - `WBData_W` follows its inputs.
- No X propagation: an unwritten entry reads 0 after reset.

## Structure
- Shared core package holds:
  - the `SelWB` encodings (`WB_ALU`=2'b00, `WB_LOAD`=2'b01, `WB_PC4`=2'b10);
  - the active-low write-enable constants;
  - `DW`/`AW` defaults.
- One natural sub-module, `wb_mux`: the combinational 4:1 writeback select. It is reused by the forwarding unit.
- The array, reset clear and bypass logic live in `wb_regfile` itself.

## Test plan
- Reset: hold `RSTN`=0 and sweep `RA1`/`RA2` over 0..31 -> `RD1`=`RD2`=0 for every address; release reset and re-sweep -> still 0.
- Mux and write:
  - Cycle 1: `WEN_W`=0, `WA_W`=3, `SelWB_W`=01, `LoadData_W`=0xDEADBEEF, `ALUOUT_W`=0x1111 -> `WBData_W`=0xDEADBEEF; the next cycle `RA1`=3 reads 0xDEADBEEF.
  - Repeat with `SelWB_W`=10 and `PCADD4_W`=0x104 -> 0x104.
  - Repeat with `SelWB_W`=11 and `ALUOUT_W`=0x1111 -> 0x1111.
- Bypass: R7=0x5; in the same cycle `WEN_W`=0, `WA_W`=7, `ALUOUT_W`=0xA, `RA1`=`RA2`=7 -> `RD1`=`RD2`=0xA combinationally, and R7=0xA after the edge.
- Write disabled: `WEN_W`=1, `WA_W`=9, `ALUOUT_W`=0xFF, `RA1`=9 -> `RD1` stays at the old R9 (0); R9 remains 0 after the edge.
- R0 writable: write 0x77 to R0 -> `RA2`=0 reads 0x77 the next cycle.
- Mid-operation reset: fill R1..R31 with their indices, pulse `RSTN` low between clock edges -> all reads are 0 immediately; a write on the first edge after release (R2←0x33) reads back 0x33.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared core definitions for the writeback stage and the forwarding unit.
//   - writeback source select encodings
//   - active-low register write-enable levels
//   - default data and register-address widths
package wb_regfile_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } sel_wb_e;

    // Register write enable is active-low.
    localparam logic WEN_ON  = 1'b0;
    localparam logic WEN_OFF = 1'b1;

endpackage

// File: rtl/wb_mux.sv
// Combinational 4:1 writeback source select; also used by the forwarding unit.
// Ports:
//   sel      : writeback source select (sel_wb_e encoding)
//   alu_out  : ALU result
//   load_data: load data
//   pc_add4  : link value (PC+4)
//   wb_data  : selected writeback value
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] load_data,
    input  logic [DW-1:0] pc_add4,
    output logic [DW-1:0] wb_data
);

    always_comb begin
        wb_data = alu_out;
        case (sel_wb_e'(sel))
            WB_LOAD: wb_data = load_data;
            WB_PC4:  wb_data = pc_add4;
            // The reserved code falls back to the ALU result.
            default: wb_data = alu_out;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus architectural register file.
// Selects the writeback value, commits it on posedge CLK, and serves two
// combinational read ports with same-cycle write-through bypass.
// Ports:
//   CLK, RSTN   : clock, asynchronous active-low reset
//   SelWB_W     : writeback source select
//   WEN_W       : register write enable, active-low
//   ALUOUT_W, LoadData_W, PCADD4_W : writeback candidates
//   WA_W        : write address
//   RA1, RA2    : read addresses
//   RD1, RD2    : read data (combinational, zero while in reset)
//   WBData_W    : selected writeback value for forwarding (never reset-gated)
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [1:0]    SelWB_W,
    input  logic          WEN_W,
    input  logic [DW-1:0] ALUOUT_W,
    input  logic [DW-1:0] LoadData_W,
    input  logic [DW-1:0] PCADD4_W,
    input  logic [AW-1:0] WA_W,
    input  logic [AW-1:0] RA1,
    input  logic [AW-1:0] RA2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic [DW-1:0] WBData_W
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs [NREG];
    logic          wr_active;

    wb_mux #(.DW(DW)) u_wb_mux (
        .sel       (SelWB_W),
        .alu_out   (ALUOUT_W),
        .load_data (LoadData_W),
        .pc_add4   (PCADD4_W),
        .wb_data   (WBData_W)
    );

    assign wr_active = (WEN_W == WEN_ON);

    // R0 is an ordinary register here; there is no hardwired zero.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[WA_W] <= WBData_W;
        end
    end

    // Write-through bypass covers a WB-to-ID distance of zero without a stall.
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (RSTN) begin
            RD1 = (wr_active && (WA_W == RA1)) ? WBData_W : regs[RA1];
            RD2 = (wr_active && (WA_W == RA2)) ? WBData_W : regs[RA2];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        CLK;
    logic        RSTN;
    logic [1:0]  SelWB_W;
    logic        WEN_W;
    logic [31:0] ALUOUT_W;
    logic [31:0] LoadData_W;
    logic [31:0] PCADD4_W;
    logic [4:0]  WA_W;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WBData_W;

    int n_checks = 0;
    int n_errors = 0;

    wb_regfile dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .SelWB_W    (SelWB_W),
        .WEN_W      (WEN_W),
        .ALUOUT_W   (ALUOUT_W),
        .LoadData_W (LoadData_W),
        .PCADD4_W   (PCADD4_W),
        .WA_W       (WA_W),
        .RA1        (RA1),
        .RA2        (RA2),
        .RD1        (RD1),
        .RD2        (RD2),
        .WBData_W   (WBData_W)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Present a write, check the mux output, commit it, then read it back.
    task automatic do_write(input logic [1:0] sel, input logic [31:0] alu,
                            input logic [31:0] ld, input logic [31:0] pc4,
                            input logic [4:0] wa, input logic [31:0] exp);
        SelWB_W    = sel;
        ALUOUT_W   = alu;
        LoadData_W = ld;
        PCADD4_W   = pc4;
        WA_W       = wa;
        WEN_W      = 1'b0;
        #1;
        chk("wbdata", WBData_W, exp);
        next_cycle();
        WEN_W = 1'b1;
        RA1   = wa;
        #1;
        chk("readback", RD1, exp);
    endtask

    initial begin
        RSTN = 1'b0; SelWB_W = 2'b00; WEN_W = 1'b1;
        ALUOUT_W = '0; LoadData_W = '0; PCADD4_W = '0;
        WA_W = '0; RA1 = '0; RA2 = '0;

        // Reset sweep
        #2;
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(31 - i);
            #1;
            chk("rst_rd1", RD1, 32'h0);
            chk("rst_rd2", RD2, 32'h0);
        end
        // Bypass suppressed in reset, WBData_W not gated
        WEN_W = 1'b0; WA_W = 5'd5; ALUOUT_W = 32'h99; RA1 = 5'd5;
        #1;
        chk("rst_nobypass", RD1, 32'h0);
        chk("rst_wbdata", WBData_W, 32'h99);
        WEN_W = 1'b1;
        next_cycle();
        RSTN = 1'b1;
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(31 - i);
            #1;
            chk("post_rst_rd1", RD1, 32'h0);
            chk("post_rst_rd2", RD2, 32'h0);
        end

        // Mux and write
        next_cycle();
        do_write(2'b01, 32'h1111, 32'hDEADBEEF, 32'h0, 5'd3, 32'hDEADBEEF);
        do_write(2'b10, 32'h1111, 32'hDEADBEEF, 32'h104, 5'd4, 32'h104);
        do_write(2'b11, 32'h1111, 32'hDEADBEEF, 32'h104, 5'd6, 32'h1111);
        do_write(2'b00, 32'h2222, 32'hDEADBEEF, 32'h104, 5'd8, 32'h2222);
        RA1 = 5'd3; RA2 = 5'd4;
        #1;
        chk("rd1_r3", RD1, 32'hDEADBEEF);
        chk("rd2_r4", RD2, 32'h104);

        // Bypass
        do_write(2'b00, 32'h5, 32'h0, 32'h0, 5'd7, 32'h5);
        SelWB_W = 2'b00; WEN_W = 1'b0; WA_W = 5'd7; ALUOUT_W = 32'hA;
        RA1 = 5'd7; RA2 = 5'd7;
        #1;
        chk("bypass_rd1", RD1, 32'hA);
        chk("bypass_rd2", RD2, 32'hA);
        next_cycle();
        WEN_W = 1'b1; ALUOUT_W = 32'h0;
        #1;
        chk("bypass_commit1", RD1, 32'hA);
        chk("bypass_commit2", RD2, 32'hA);

        // Write disabled
        WEN_W = 1'b1; WA_W = 5'd9; ALUOUT_W = 32'hFF; RA1 = 5'd9;
        #1;
        chk("wdis_rd1", RD1, 32'h0);
        next_cycle();
        #1;
        chk("wdis_after", RD1, 32'h0);

        // R0 writable
        do_write(2'b00, 32'h77, 32'h0, 32'h0, 5'd0, 32'h77);
        RA2 = 5'd0;
        #1;
        chk("r0_rd2", RD2, 32'h77);

        // Mid-operation reset
        for (int i = 1; i < 32; i++) begin
            SelWB_W = 2'b00; ALUOUT_W = 32'(i); WA_W = 5'(i); WEN_W = 1'b0;
            next_cycle();
        end
        WEN_W = 1'b1;
        RA1 = 5'd17; RA2 = 5'd31;
        #1;
        chk("fill_r17", RD1, 32'd17);
        chk("fill_r31", RD2, 32'd31);
        RSTN = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(i);
            #1;
            chk("mid_rst_rd1", RD1, 32'h0);
            chk("mid_rst_rd2", RD2, 32'h0);
        end
        @(posedge CLK);
        #2;
        WEN_W = 1'b0; WA_W = 5'd2; ALUOUT_W = 32'h33; SelWB_W = 2'b00;
        RSTN = 1'b1;
        RA1 = 5'd5; RA2 = 5'd31;
        #1;
        chk("cleared_r5", RD1, 32'h0);
        chk("cleared_r31", RD2, 32'h0);
        next_cycle();
        WEN_W = 1'b1; ALUOUT_W = 32'h0;
        RA1 = 5'd2; RA2 = 5'd1;
        #1;
        chk("post_rst_r2", RD1, 32'h33);
        chk("post_rst_r1", RD2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
